// File: rtl/lsu.sv
// MEM-stage load-store unit: byte-lane data memory plus LED/7-seg/switch/button
// registers, with one-cycle registered load data and access-fault flag.
module lsu #(
  parameter int          DMEM_WORDS = 2048,
  parameter logic [31:0] DMEM_BASE  = 32'h0000_2000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] st_data_i,
  input  logic        st_en_i,
  input  logic        ld_en_i,
  input  logic [2:0]  funct3_i,
  input  logic [17:0] sw_i,
  input  logic [3:0]  btn_i,
  output logic [31:0] ld_data_o,
  output logic        err_o,
  output logic [17:0] ledr_o,
  output logic [7:0]  ledg_o,
  output logic [31:0] hex_o
);

  localparam int          IDX_W      = $clog2(DMEM_WORDS);
  localparam logic [32:0] DMEM_BYTES = 33'(4 * DMEM_WORDS);

  logic [17:0] sw_s1_reg, sw_s2_reg;
  logic [3:0]  btn_s1_reg, btn_s2_reg;
  logic [17:0] ledr_reg;
  logic [7:0]  ledg_reg;
  logic [31:0] hex_reg;
  logic [31:0] ld_data_reg;
  logic        err_reg;

  logic [31:0] offset, waddr, wdata, rword, dmem_rdata, ld_result;
  logic [IDX_W-1:0] dmem_idx;
  logic [3:0]  be;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic in_dmem, is_ledr, is_ledg, is_hex, is_sw, is_btn;
  logic mapped, read_only, aligned, f3_ld_ok, f3_st_ok, st_ok, ld_ok, dmem_we;

  // Address decode and access legality
  always_comb begin
    offset   = addr_i - DMEM_BASE;
    in_dmem  = (addr_i >= DMEM_BASE) && ({1'b0, offset} < DMEM_BYTES);
    dmem_idx = offset[IDX_W+1:2];
    waddr    = {addr_i[31:2], 2'b00};
    is_ledr  = (waddr == 32'h0000_7000);
    is_ledg  = (waddr == 32'h0000_7010);
    is_hex   = (waddr == 32'h0000_7020);
    is_sw    = (waddr == 32'h0000_7800);
    is_btn   = (waddr == 32'h0000_7810);
    mapped    = in_dmem | is_ledr | is_ledg | is_hex | is_sw | is_btn;
    read_only = is_sw | is_btn;
    f3_ld_ok  = funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    f3_st_ok  = funct3_i inside {3'b000, 3'b001, 3'b010};
    aligned   = !((funct3_i[1:0] == 2'b01 && addr_i[0]) ||
                  (funct3_i[1:0] == 2'b10 && addr_i[1:0] != 2'b00));
    st_ok   = st_en_i && f3_st_ok && aligned && mapped && !read_only;
    ld_ok   = ld_en_i && f3_ld_ok && aligned && mapped;
    dmem_we = st_ok && in_dmem;
  end

  // Byte enables and lane-replicated store data
  always_comb begin
    be    = 4'b1111;
    wdata = st_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_i[1:0];
        wdata = {4{st_data_i[7:0]}};
      end
      2'b01: begin
        be    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata = {2{st_data_i[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = st_data_i;
      end
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DMEM_WORDS];
      always_ff @(posedge clk_i) begin
        if (dmem_we && be[gi]) mem[dmem_idx] <= wdata[8*gi +: 8];
      end
      assign dmem_rdata[8*gi +: 8] = mem[dmem_idx];
    end
  endgenerate

  // Source word select, lane extraction and extension
  always_comb begin
    rword = 32'h0;
    if (in_dmem)      rword = dmem_rdata;
    else if (is_ledr) rword = {14'h0, ledr_reg};
    else if (is_ledg) rword = {24'h0, ledg_reg};
    else if (is_hex)  rword = hex_reg;
    else if (is_sw)   rword = {14'h0, sw_s2_reg};
    else if (is_btn)  rword = {28'h0, btn_s2_reg};

    case (addr_i[1:0])
      2'b00:   sel_byte = rword[7:0];
      2'b01:   sel_byte = rword[15:8];
      2'b10:   sel_byte = rword[23:16];
      default: sel_byte = rword[31:24];
    endcase
    sel_half = addr_i[1] ? rword[31:16] : rword[15:0];

    case (funct3_i)
      3'b000:  ld_result = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  ld_result = {24'h0, sel_byte};
      3'b001:  ld_result = {{16{sel_half[15]}}, sel_half};
      3'b101:  ld_result = {16'h0, sel_half};
      default: ld_result = rword;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sw_s1_reg   <= '0;
      sw_s2_reg   <= '0;
      btn_s1_reg  <= '0;
      btn_s2_reg  <= '0;
      ledr_reg    <= '0;
      ledg_reg    <= '0;
      hex_reg     <= '0;
      ld_data_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      sw_s1_reg  <= sw_i;
      sw_s2_reg  <= sw_s1_reg;
      btn_s1_reg <= btn_i;
      btn_s2_reg <= btn_s1_reg;

      // Peripheral lanes beyond the register width are silently dropped
      if (st_ok && is_ledr) begin
        if (be[0]) ledr_reg[7:0]   <= wdata[7:0];
        if (be[1]) ledr_reg[15:8]  <= wdata[15:8];
        if (be[2]) ledr_reg[17:16] <= wdata[17:16];
      end
      if (st_ok && is_ledg && be[0]) ledg_reg <= wdata[7:0];
      if (st_ok && is_hex) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) hex_reg[8*i +: 8] <= wdata[8*i +: 8];
        end
      end

      if (ld_en_i && st_en_i) begin
        ld_data_reg <= '0;
        err_reg     <= 1'b1;
      end else if (ld_en_i) begin
        ld_data_reg <= ld_ok ? ld_result : 32'h0;
        err_reg     <= !ld_ok;
      end else if (st_en_i) begin
        ld_data_reg <= '0;
        err_reg     <= !st_ok;
      end else begin
        ld_data_reg <= '0;
        err_reg     <= 1'b0;
      end
    end
  end

  assign ld_data_o = ld_data_reg;
  assign err_o     = err_reg;
  assign ledr_o    = ledr_reg;
  assign ledg_o    = ledg_reg;
  assign hex_o     = hex_reg;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: stimulus queues expected load/err results, a monitor
// compares them one cycle after each checked request.
module tb_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] st_data_i = '0;
  logic        st_en_i = 1'b0;
  logic        ld_en_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [17:0] sw_i = '0;
  logic [3:0]  btn_i = '0;
  logic [31:0] ld_data_o;
  logic        err_o;
  logic [17:0] ledr_o;
  logic [7:0]  ledg_o;
  logic [31:0] hex_o;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  logic chk = 1'b0;
  int   tests = 0;
  int   fails = 0;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  lsu dut (
    .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .st_data_i(st_data_i),
    .st_en_i(st_en_i), .ld_en_i(ld_en_i), .funct3_i(funct3_i),
    .sw_i(sw_i), .btn_i(btn_i), .ld_data_o(ld_data_o), .err_o(err_o),
    .ledr_o(ledr_o), .ledg_o(ledg_o), .hex_o(hex_o)
  );

  always #5 clk_i = ~clk_i;

  // Monitor: a checked request sampled at this edge has its result visible just after it
  always @(posedge clk_i) begin
    logic do_chk;
    exp_t e;
    do_chk = chk;
    #1;
    if (do_chk) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_empty: result ld=%h err=%b with no expectation", ld_data_o, err_o);
      end else begin
        e = exp_q.pop_front();
        if (ld_data_o !== e.data || err_o !== e.err) begin
          fails++;
          $display("FAIL %s: got ld=%h err=%b, expected ld=%h err=%b",
                   e.name, ld_data_o, err_o, e.data, e.err);
        end else begin
          $display("[TB] %s: ld=%h err=%b ok", e.name, ld_data_o, err_o);
        end
      end
    end
  end

  task automatic issue(input string name, input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] exp_data, input logic exp_err);
    exp_t e;
    @(negedge clk_i);
    ld_en_i = ld; st_en_i = st; funct3_i = f3; addr_i = addr; st_data_i = data;
    e.name = name; e.data = exp_data; e.err = exp_err;
    exp_q.push_back(e);
    chk = 1'b1;
    @(posedge clk_i);
    #2;
    ld_en_i = 1'b0; st_en_i = 1'b0; chk = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end else begin
      $display("[TB] %s: %h ok", name, got);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_i = 1'b1;
    #3;
    check("reset_ld_data", ld_data_o, 32'h0);
    check("reset_err", {31'h0, err_o}, 32'h0);
    check("reset_ledr", {14'h0, ledr_o}, 32'h0);
    check("reset_ledg", {24'h0, ledg_o}, 32'h0);
    check("reset_hex", hex_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Basic DMEM word, byte and halfword traffic
    issue("sw_2000",       0, 1, LW,  32'h2000, 32'hDEADBEEF, 32'h0, 0);
    issue("lw_2000",       1, 0, LW,  32'h2000, 32'h0, 32'hDEADBEEF, 0);
    issue("sb_2003",       0, 1, LB,  32'h2003, 32'h00000080, 32'h0, 0);
    issue("lb_2003",       1, 0, LB,  32'h2003, 32'h0, 32'hFFFFFF80, 0);
    issue("lbu_2003",      1, 0, LBU, 32'h2003, 32'h0, 32'h00000080, 0);
    issue("lh_2002",       1, 0, LH,  32'h2002, 32'h0, 32'hFFFF80AD, 0);
    issue("lw_misaligned", 1, 0, LW,  32'h2002, 32'h0, 32'h0, 1);
    issue("sh_misaligned", 0, 1, LH,  32'h2001, 32'h00001234, 32'h0, 1);
    issue("idle_clears",   0, 0, LB,  32'h0, 32'h0, 32'h0, 0);
    issue("lw_unchanged",  1, 0, LW,  32'h2000, 32'h0, 32'h80ADBEEF, 0);
    issue("sh_2002",       0, 1, LH,  32'h2002, 32'h1111CAFE, 32'h0, 0);
    issue("lh_2002_b",     1, 0, LH,  32'h2002, 32'h0, 32'hFFFFCAFE, 0);
    issue("lhu_2000",      1, 0, LHU, 32'h2000, 32'h0, 32'h0000BEEF, 0);
    issue("lb_2001",       1, 0, LB,  32'h2001, 32'h0, 32'hFFFFFFBE, 0);
    issue("lbu_2000",      1, 0, LBU, 32'h2000, 32'h0, 32'h000000EF, 0);
    issue("ld_f3_011",     1, 0, 3'b011, 32'h2000, 32'h0, 32'h0, 1);
    issue("st_f3_100",     0, 1, LBU, 32'h2000, 32'h0, 32'h0, 1);
    issue("lw_after_bad",  1, 0, LW,  32'h2000, 32'h0, 32'hCAFEBEEF, 0);

    // DMEM boundaries
    issue("sw_top",        0, 1, LW,  32'h3FFC, 32'h12345678, 32'h0, 0);
    issue("lw_top",        1, 0, LW,  32'h3FFC, 32'h0, 32'h12345678, 0);
    issue("lw_above",      1, 0, LW,  32'h4000, 32'h0, 32'h0, 1);
    issue("lw_below",      1, 0, LW,  32'h1FFC, 32'h0, 32'h0, 1);
    issue("lw_unmapped",   1, 0, LW,  32'h9000, 32'h0, 32'h0, 1);

    // Load and store together: store still lands
    issue("ld_st_both",    1, 1, LW,  32'h2004, 32'h00000055, 32'h0, 1);
    issue("lw_2004",       1, 0, LW,  32'h2004, 32'h0, 32'h00000055, 0);

    // Peripherals
    issue("sw_ledr",       0, 1, LW,  32'h7000, 32'h0003FFFF, 32'h0, 0);
    check("ledr_value", {14'h0, ledr_o}, 32'h0003FFFF);
    issue("lw_ledr",       1, 0, LW,  32'h7000, 32'h0, 32'h0003FFFF, 0);
    issue("sb_ledg",       0, 1, LB,  32'h7010, 32'h000000A5, 32'h0, 0);
    issue("sb_ledg_lane1", 0, 1, LB,  32'h7011, 32'h00000011, 32'h0, 0);
    check("ledg_value", {24'h0, ledg_o}, 32'h000000A5);
    issue("sh_hex_hi",     0, 1, LH,  32'h7022, 32'h0000BEEF, 32'h0, 0);
    check("hex_value", hex_o, 32'hBEEF0000);
    issue("lw_hex",        1, 0, LW,  32'h7020, 32'h0, 32'hBEEF0000, 0);
    issue("sw_to_sw_reg",  0, 1, LW,  32'h7800, 32'hFFFFFFFF, 32'h0, 1);
    check("ledr_kept", {14'h0, ledr_o}, 32'h0003FFFF);

    // Synchroniser depth: a load one edge after the change still sees the old value
    @(negedge clk_i);
    sw_i = 18'h155AA;
    btn_i = 4'hA;
    issue("lw_sw_early",   1, 0, LW,  32'h7800, 32'h0, 32'h0, 0);
    issue("lw_sw",         1, 0, LW,  32'h7800, 32'h0, 32'h000155AA, 0);
    issue("lbu_btn",       1, 0, LBU, 32'h7810, 32'h0, 32'h0000000A, 0);

    // Asynchronous reset between edges with non-zero outputs
    issue("lw_pre_reset",  1, 0, LW,  32'h2000, 32'h0, 32'hCAFEBEEF, 0);
    #1;
    rst_i = 1'b1;
    #1;
    check("async_rst_ld", ld_data_o, 32'h0);
    check("async_rst_ledr", {14'h0, ledr_o}, 32'h0);
    check("async_rst_ledg", {24'h0, ledg_o}, 32'h0);
    check("async_rst_hex", hex_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    issue("lw_sw_post_rst", 1, 0, LW, 32'h7800, 32'h0, 32'h0, 0);

    repeat (3) @(posedge clk_i);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
